// File: rtl/sc_level_pkg.sv
// Shared definitions for the level-advance controller.
//   state_e             : controller state encoding (3-bit, fixed values)
//   DefEventsPerLevel   : default events needed for one level advance
//   DefMaxLevel         : default terminal level
//   DefAckTimeout       : default WAIT_ACK cycles before ERROR
package sc_level_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StRun     = 3'd2,
        StAdvance = 3'd3,
        StWaitAck = 3'd4,
        StMaxed   = 3'd5,
        StError   = 3'd6
    } state_e;

    localparam int unsigned DefEventsPerLevel = 5;
    localparam int unsigned DefMaxLevel       = 3;
    localparam int unsigned DefAckTimeout     = 4;

endpackage

// File: rtl/sc_level_event_counter.sv
// Saturating event counter with synchronous load-0 / load-1 and increment enable.
// Priority: load0_i > load1_i > inc_i. Holds at all-ones instead of wrapping.
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset (count -> 0)
//   load0_i  : synchronous load of 0
//   load1_i  : synchronous load of 1
//   inc_i    : increment by one, saturating
//   count_o  : current count
module sc_level_event_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load0_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load0_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = Width'(1);
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sc_level_advance_ctrl.sv
// Initiator-side controller for the level register. Counts game events, issues one-cycle
// active-low clear / change-level strobes to the register and confirms each advance by
// reading the register's level bus back. Reports win (MAXED) and handshake error (ERROR).
// Optional feature: define SC_LVLCTRL_SKIP_EN to add SC_LvlCtrl_skip_InLow, which forces
// an advance from RUN regardless of the event count.
// Ports:
//   SC_RegNIVEL_CLOCK_50            : system clock
//   SC_RegNIVEL_RESET_InHigh        : asynchronous active-high reset
//   SC_LvlCtrl_start_InLow          : new-game request (active low, per cycle)
//   SC_LvlCtrl_skip_InLow           : forced advance request (only with SC_LVLCTRL_SKIP_EN)
//   SC_LvlCtrl_event_InLow          : one event per low cycle
//   SC_LvlCtrl_level_InBUS          : level register read-back
//   SC_LvlCtrl_clear_OutLow         : register clear strobe, low only in CLEAR
//   SC_LvlCtrl_change_level_OutLow  : register advance strobe, low only in ADVANCE
//   SC_LvlCtrl_events_OutBUS        : current event count
//   SC_LvlCtrl_win_OutHigh          : high in MAXED
//   SC_LvlCtrl_error_OutHigh        : high in ERROR
module sc_level_advance_ctrl
    import sc_level_pkg::*;
#(
    parameter int unsigned LEVEL_DATAWIDTH  = 2,
    parameter int unsigned EVENT_CNT_WIDTH  = 4,
    parameter int unsigned EVENTS_PER_LEVEL = DefEventsPerLevel,
    parameter int unsigned MAX_LEVEL        = DefMaxLevel,
    parameter int unsigned ACK_TIMEOUT      = DefAckTimeout
) (
    input  logic                       SC_RegNIVEL_CLOCK_50,
    input  logic                       SC_RegNIVEL_RESET_InHigh,
    input  logic                       SC_LvlCtrl_start_InLow,
`ifdef SC_LVLCTRL_SKIP_EN
    input  logic                       SC_LvlCtrl_skip_InLow,
`endif
    input  logic                       SC_LvlCtrl_event_InLow,
    input  logic [LEVEL_DATAWIDTH-1:0] SC_LvlCtrl_level_InBUS,
    output logic                       SC_LvlCtrl_clear_OutLow,
    output logic                       SC_LvlCtrl_change_level_OutLow,
    output logic [EVENT_CNT_WIDTH-1:0] SC_LvlCtrl_events_OutBUS,
    output logic                       SC_LvlCtrl_win_OutHigh,
    output logic                       SC_LvlCtrl_error_OutHigh
);

    localparam int unsigned TimeoutW = $clog2(ACK_TIMEOUT + 1);

    state_e                     state_d, state_q;
    logic [LEVEL_DATAWIDTH-1:0] expected_d, expected_q;
    logic [TimeoutW-1:0]        timeout_d, timeout_q;
    logic [EVENT_CNT_WIDTH-1:0] count;

    logic start_req, event_req, skip_req;
    logic level_at_max, count_at_thr;
    logic cnt_load0, cnt_load1, cnt_inc;

    assign start_req = ~SC_LvlCtrl_start_InLow;
    assign event_req = ~SC_LvlCtrl_event_InLow;
`ifdef SC_LVLCTRL_SKIP_EN
    assign skip_req  = ~SC_LvlCtrl_skip_InLow;
`else
    assign skip_req  = 1'b0;
`endif

    // Compare at 32 bits so parameter values wider than the buses are not truncated.
    assign level_at_max = (32'(SC_LvlCtrl_level_InBUS) >= MAX_LEVEL);
    assign count_at_thr = (32'(count) >= EVENTS_PER_LEVEL);

    sc_level_event_counter #(
        .Width (EVENT_CNT_WIDTH)
    ) u_event_counter (
        .clk_i   (SC_RegNIVEL_CLOCK_50),
        .rst_i   (SC_RegNIVEL_RESET_InHigh),
        .load0_i (cnt_load0),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        timeout_d  = timeout_q;
        cnt_load0  = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;

        // A start request outranks everything except an ongoing CLEAR.
        if (start_req && (state_q != StClear)) begin
            state_d = StClear;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StClear: begin
                    cnt_load0 = 1'b1;
                    state_d   = StRun;
                end
                StRun: begin
                    if (level_at_max) begin
                        state_d = StMaxed;
                    end else if (skip_req) begin
                        cnt_load0 = 1'b1;
                        state_d   = StAdvance;
                    end else if (count_at_thr) begin
                        // The event on the advancing cycle starts the next level's count.
                        cnt_load1 = event_req;
                        cnt_load0 = ~event_req;
                        state_d   = StAdvance;
                    end else begin
                        cnt_inc = event_req;
                    end
                end
                StAdvance: begin
                    expected_d = SC_LvlCtrl_level_InBUS + LEVEL_DATAWIDTH'(1);
                    timeout_d  = '0;
                    cnt_inc    = event_req;
                    state_d    = StWaitAck;
                end
                StWaitAck: begin
                    cnt_inc = event_req;
                    if (SC_LvlCtrl_level_InBUS == expected_q) begin
                        state_d = StRun;
                    end else begin
                        timeout_d = timeout_q + TimeoutW'(1);
                        if (32'(timeout_d) >= ACK_TIMEOUT) begin
                            state_d = StError;
                        end
                    end
                end
                default: begin
                    // MAXED and ERROR hold until a start request.
                end
            endcase
        end
    end

    always_ff @(posedge SC_RegNIVEL_CLOCK_50 or posedge SC_RegNIVEL_RESET_InHigh) begin
        if (SC_RegNIVEL_RESET_InHigh) begin
            state_q    <= StIdle;
            expected_q <= '0;
            timeout_q  <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            timeout_q  <= timeout_d;
        end
    end

    // Moore outputs decoded from the state register only.
    assign SC_LvlCtrl_clear_OutLow        = (state_q != StClear);
    assign SC_LvlCtrl_change_level_OutLow = (state_q != StAdvance);
    assign SC_LvlCtrl_win_OutHigh         = (state_q == StMaxed);
    assign SC_LvlCtrl_error_OutHigh       = (state_q == StError);
    assign SC_LvlCtrl_events_OutBUS       = count;

endmodule

// File: tb/tb_sc_level_advance_ctrl.sv
module tb_sc_level_advance_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_n;
    logic       event_n;
    logic [1:0] level;
    logic       clear_n;
    logic       change_n;
    logic [3:0] events;
    logic       win;
    logic       error;
`ifdef SC_LVLCTRL_SKIP_EN
    logic       skip_n = 1'b1;
`endif

    // Level register model: clear has priority over change-level.
    logic reg_connected;

    int total = 0;
    int bad   = 0;
    int clr_cnt = 0;
    int chg_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #10 clk = ~clk;

    sc_level_advance_ctrl dut (
        .SC_RegNIVEL_CLOCK_50           (clk),
        .SC_RegNIVEL_RESET_InHigh       (rst),
        .SC_LvlCtrl_start_InLow         (start_n),
`ifdef SC_LVLCTRL_SKIP_EN
        .SC_LvlCtrl_skip_InLow          (skip_n),
`endif
        .SC_LvlCtrl_event_InLow         (event_n),
        .SC_LvlCtrl_level_InBUS         (level),
        .SC_LvlCtrl_clear_OutLow        (clear_n),
        .SC_LvlCtrl_change_level_OutLow (change_n),
        .SC_LvlCtrl_events_OutBUS       (events),
        .SC_LvlCtrl_win_OutHigh         (win),
        .SC_LvlCtrl_error_OutHigh       (error)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 2'd0;
        end else if (!clear_n) begin
            level <= 2'd0;
        end else if (!change_n && reg_connected) begin
            level <= level + 2'd1;
        end
    end

    // Strobe monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!clear_n)  clr_cnt++;
            if (!change_n) chg_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic pulse_start();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        tick();
    endtask

    // One low cycle followed by one high cycle.
    task automatic send_event();
        event_n = 1'b0;
        tick();
        event_n = 1'b1;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        start_n       = 1'b1;
        event_n       = 1'b1;
        reg_connected = 1'b1;
        tick();
        tick();

        // Reset state.
        push("rst_clear_n", 1);
        push("rst_change_n", 1);
        push("rst_events", 0);
        push("rst_win", 0);
        push("rst_error", 0);
        check_next(32'(clear_n));
        check_next(32'(change_n));
        check_next(32'(events));
        check_next(32'(win));
        check_next(32'(error));
        rst = 1'b0;
        tick();

        // 1: start -> one-cycle clear, level 0, events 0.
        clr_cnt = 0;
        push("start_clear_low", 0);
        push("start_clear_pulses", 1);
        push("start_level", 0);
        push("start_events", 0);
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        check_next(32'(clear_n));
        tick();
        tick();
        tick();
        check_next(32'(clr_cnt));
        check_next(32'(level));
        check_next(32'(events));

        // 2: five events -> one advance pulse, level 1, count back to 0.
        chg_cnt = 0;
        push("adv_pulses", 1);
        push("adv_level", 1);
        push("adv_events", 0);
        for (int i = 0; i < 5; i++) send_event();
        repeat (4) tick();
        check_next(32'(chg_cnt));
        check_next(32'(level));
        check_next(32'(events));

        // 3: restart, 15 events -> level 3 and win; a further event is ignored.
        pulse_start();
        chg_cnt = 0;
        push("max_pulses", 3);
        push("max_level", 3);
        push("max_win", 1);
        push("max_events", 0);
        push("max_events_after", 0);
        for (int i = 0; i < 15; i++) send_event();
        repeat (4) tick();
        check_next(32'(chg_cnt));
        check_next(32'(level));
        check_next(32'(win));
        check_next(32'(events));
        send_event();
        check_next(32'(events));

        // 4: register ignores change-level -> ERROR after four WAIT_ACK cycles.
        reg_connected = 1'b0;
        pulse_start();
        push("to_in_advance", 0);
        push("to_error_last_wait", 0);
        push("to_error_set", 1);
        push("to_events_ignored", 0);
        push("to_restart_clear", 0);
        push("to_restart_error", 0);
        for (int i = 0; i < 5; i++) send_event();
        check_next(32'(change_n));
        repeat (4) tick();
        check_next(32'(error));
        tick();
        check_next(32'(error));
        send_event();
        check_next(32'(events));
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        check_next(32'(clear_n));
        check_next(32'(error));
        tick();
        reg_connected = 1'b1;

        // 5: event on the RUN->ADVANCE cycle plus events in ADVANCE and WAIT_ACK.
        chg_cnt = 0;
        push("carry_events", 3);
        push("carry_level", 1);
        push("carry_pulses", 1);
        for (int i = 0; i < 4; i++) send_event();
        event_n = 1'b0;
        repeat (4) tick();
        event_n = 1'b1;
        repeat (3) tick();
        check_next(32'(events));
        check_next(32'(level));
        check_next(32'(chg_cnt));

        // 6: start during WAIT_ACK -> CLEAR next, level back to 0, no new advance.
        reg_connected = 1'b0;
        chg_cnt = 0;
        push("wa_start_clear", 0);
        push("wa_level", 0);
        push("wa_pulses", 1);
        push("wa_events", 0);
        push("wa_error", 0);
        send_event();
        send_event();
        tick();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        check_next(32'(clear_n));
        repeat (6) tick();
        check_next(32'(level));
        check_next(32'(chg_cnt));
        check_next(32'(events));
        check_next(32'(error));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
